// File: rtl/cache_mem_adapter_if.sv
// Cache-side request/response and one-word RAM port bundle for cache_mem_adapter.
// The slave modport is the adapter's view; master is the environment (cache + RAM).
interface cache_mem_adapter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int BLOCK_SIZE = 2
) ();
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic                             req_cs;
    logic                             req_rw;
    logic [BLOCK_SIZE*WORD_WIDTH-1:0] req_data;
    logic                             resp_ack;
    logic [BLOCK_SIZE*WORD_WIDTH-1:0] resp_data;
    logic                             ram_cs;
    logic                             ram_we;
    logic [ADDR_WIDTH-1:0]            ram_addr;
    logic [WORD_WIDTH-1:0]            ram_wdata;
    logic [WORD_WIDTH-1:0]            ram_rdata;

    modport slave (
        input  req_addr, req_cs, req_rw, req_data, ram_rdata,
        output resp_ack, resp_data, ram_cs, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_addr, req_cs, req_rw, req_data, ram_rdata,
        input  resp_ack, resp_data, ram_cs, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/cache_mem_adapter.sv
// Serialises a cache block request into single-word RAM beats and returns a one-cycle ack.
// Optional: CACHE_MEM_CRITICAL_WORD_FIRST_EN starts reads at the requested word offset.
module cache_mem_adapter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_SIZE  = 2,
    parameter int RAM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_adapter_if.slave  bus
);
    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int CNT_W = $clog2(RAM_LATENCY + 1);
    localparam int BLK_W = BLOCK_SIZE * WORD_WIDTH;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_BEAT  = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0]                  r_state;
    logic [ADDR_WIDTH-OFF_W-1:0] r_addr_hi;
    logic [BLK_W-1:0]            r_data;
    logic [OFF_W-1:0]            r_off;
    logic [OFF_W-1:0]            r_beat;
    logic [CNT_W-1:0]            r_wait;
    logic                        r_resp_ack;
    logic [BLK_W-1:0]            r_resp_data;
    logic                        r_ram_cs;
    logic                        r_ram_we;
    logic [ADDR_WIDTH-1:0]       r_ram_addr;
    logic [WORD_WIDTH-1:0]       r_ram_wdata;

    logic [OFF_W-1:0]            w_start_off;
    logic [OFF_W-1:0]            w_next_off;
    logic                        w_last_beat;

    // Offset sequencing: the offset wraps inside its own field, upper address bits never move.
    always_comb begin
        w_start_off = {OFF_W{1'b0}};
`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
        if (!bus.req_rw) begin
            w_start_off = bus.req_addr[OFF_W-1:0];
        end else begin
            w_start_off = {OFF_W{1'b0}};
        end
`endif
        w_next_off  = r_off + OFF_W'(1);
        w_last_beat = (r_beat == OFF_W'(BLOCK_SIZE - 1));
    end

    // Transfer FSM; RAM and response outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr_hi   <= '0;
            r_data      <= '0;
            r_off       <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_resp_ack  <= 1'b0;
            r_resp_data <= '0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_resp_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_cs) begin
                        r_addr_hi   <= bus.req_addr[ADDR_WIDTH-1:OFF_W];
                        r_data      <= bus.req_data;
                        r_off       <= w_start_off;
                        r_beat      <= '0;
                        r_wait      <= '0;
                        r_ram_cs    <= 1'b1;
                        r_ram_we    <= bus.req_rw;
                        r_ram_addr  <= {bus.req_addr[ADDR_WIDTH-1:OFF_W], w_start_off};
                        r_ram_wdata <= bus.req_data[w_start_off*WORD_WIDTH +: WORD_WIDTH];
                        r_state     <= bus.req_rw ? S_WR_BEAT : S_RD_ISSUE;
                    end
                end
                S_WR_BEAT: begin
                    if (w_last_beat) begin
                        r_ram_cs   <= 1'b0;
                        r_ram_we   <= 1'b0;
                        r_resp_ack <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_beat      <= r_beat + OFF_W'(1);
                        r_off       <= w_next_off;
                        r_ram_addr  <= {r_addr_hi, w_next_off};
                        r_ram_wdata <= r_data[w_next_off*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
                S_RD_ISSUE: begin
                    r_ram_cs <= 1'b0;
                    r_wait   <= CNT_W'(1);
                    r_state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // r_wait counts cycles since issue; rdata is valid on the RAM_LATENCY-th one.
                    if (r_wait == CNT_W'(RAM_LATENCY)) begin
                        r_resp_data[r_off*WORD_WIDTH +: WORD_WIDTH] <= bus.ram_rdata;
                        if (w_last_beat) begin
                            r_resp_ack <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_beat     <= r_beat + OFF_W'(1);
                            r_off      <= w_next_off;
                            r_ram_addr <= {r_addr_hi, w_next_off};
                            r_ram_cs   <= 1'b1;
                            r_state    <= S_RD_ISSUE;
                        end
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ram_cs <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.resp_ack  = r_resp_ack;
    assign bus.resp_data = r_resp_data;
    assign bus.ram_cs    = r_ram_cs;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_cache_mem_adapter.sv
// Scoreboard bench for cache_mem_adapter: stimulus pushes expected RAM beats and acks,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_cache_mem_adapter;
    localparam int AW = 32;
    localparam int WW = 32;
`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
    localparam int BS = 4;
`else
    localparam int BS = 2;
`endif
    localparam int L  = 1;
    localparam int OW = $clog2(BS);
    localparam int BW = BS * WW;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
    } ram_exp_t;

    typedef struct {
        int            cyc;
        logic [BW-1:0] data;
    } ack_exp_t;

    logic     clk;
    logic     rst;
    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    ram_exp_t ram_q[$];
    ack_exp_t ack_q[$];
    ram_exp_t m_re;
    ack_exp_t m_ae;
    logic [BW-1:0] exp_block = '0;

    cache_mem_adapter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS)) bus ();

    cache_mem_adapter #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .BLOCK_SIZE (BS),
        .RAM_LATENCY(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency RAM: addr ^ 0x5A5A, garbage whenever no read was issued last cycle.
    always @(posedge clk)
        bus.ram_rdata <= (bus.ram_cs && !bus.ram_we) ? (bus.ram_addr ^ 32'h0000_5A5A) : 32'hDEAD_BEEF;

    // Monitor: every RAM access and every ack must match the head of its expectation queue.
    always @(negedge clk) begin
        if (bus.ram_cs) begin
            checks++;
            if (ram_q.size() == 0) begin
                failures++;
                $display("FAIL ram_unexpected cyc=%0d got addr=%h we=%b, expected no access",
                         cyc, bus.ram_addr, bus.ram_we);
            end else begin
                m_re = ram_q.pop_front();
                if (cyc != m_re.cyc || bus.ram_we !== m_re.we || bus.ram_addr !== m_re.addr ||
                    (m_re.we && bus.ram_wdata !== m_re.wdata)) begin
                    failures++;
                    $display("FAIL ram_beat got cyc=%0d we=%b addr=%h wdata=%h, expected cyc=%0d we=%b addr=%h wdata=%h",
                             cyc, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                             m_re.cyc, m_re.we, m_re.addr, m_re.wdata);
                end
            end
        end
        if (bus.ram_we && !bus.ram_cs) begin
            checks++;
            failures++;
            $display("FAIL we_without_cs cyc=%0d got ram_we=1 ram_cs=0, expected ram_we=0", cyc);
        end
        if (bus.resp_ack) begin
            checks++;
            if (ack_q.size() == 0) begin
                failures++;
                $display("FAIL ack_unexpected cyc=%0d got resp_ack=1, expected 0", cyc);
            end else begin
                m_ae = ack_q.pop_front();
                if (cyc != m_ae.cyc || bus.resp_data !== m_ae.data) begin
                    failures++;
                    $display("FAIL ack got cyc=%0d data=%h, expected cyc=%0d data=%h",
                             cyc, bus.resp_data, m_ae.cyc, m_ae.data);
                end
            end
        end
    end

    function automatic logic [BW-1:0] mk_block(input logic [WW-1:0] seed);
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++)
            b[i*WW +: WW] = seed + WW'(i) * 32'h1111_0001;
        return b;
    endfunction

    // Drive a request and push its expected beats/ack, with t0 the cycle it is sampled in IDLE.
    task automatic start_req(input logic [AW-1:0] a, input logic rw, input logic [BW-1:0] d,
                             input int t0, input bit abort);
        int            st;
        int            off;
        logic [AW-1:0] base;
        ram_exp_t      e;
        ack_exp_t      k;
        bus.req_addr = a;
        bus.req_rw   = rw;
        bus.req_data = d;
        bus.req_cs   = 1'b1;
        base = {a[AW-1:OW], {OW{1'b0}}};
        st = 0;
`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
        if (!rw) st = int'(a[OW-1:0]);
`endif
        for (int i = 0; i < BS; i++) begin
            off = (st + i) % BS;
            e.addr = base | AW'(off);
            if (rw) begin
                e.cyc   = t0 + 1 + i;
                e.we    = 1'b1;
                e.wdata = d[off*WW +: WW];
            end else begin
                e.cyc   = t0 + 1 + i * (L + 1);
                e.we    = 1'b0;
                e.wdata = '0;
                if (!abort) exp_block[off*WW +: WW] = e.addr ^ 32'h0000_5A5A;
            end
            if (!abort || i == 0) ram_q.push_back(e);
        end
        if (abort) begin
            exp_block = '0;
        end else begin
            k.cyc  = rw ? (t0 + BS + 1) : (t0 + 1 + BS * (L + 1));
            k.data = exp_block;
            ack_q.push_back(k);
        end
    endtask

    // Wait for ack (bounded); request inputs are scrambled after acceptance to prove they are latched.
    task automatic wait_ack(input string name, input int t0);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.resp_ack && n < 60) begin
            if (cyc > t0) begin
                bus.req_addr = bus.req_addr ^ 32'h0000_0F0F;
                bus.req_rw   = ~bus.req_rw;
                bus.req_data = ~bus.req_data;
            end
            n++;
            @(negedge clk);
        end
        if (!bus.resp_ack) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got no resp_ack within 60 cycles, expected ack", name);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (bus.resp_ack !== 1'b0 || bus.ram_cs !== 1'b0 || bus.ram_we !== 1'b0 ||
            bus.ram_addr !== '0 || bus.ram_wdata !== '0 || bus.resp_data !== '0) begin
            failures++;
            $display("FAIL %s got ack=%b cs=%b we=%b addr=%h wdata=%h rdata_blk=%h, expected all 0",
                     name, bus.resp_ack, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.resp_data);
        end
    endtask

    task automatic do_req(input string name, input logic [AW-1:0] a, input logic rw,
                          input logic [BW-1:0] d);
        int t0;
        @(negedge clk);
        t0 = cyc;
        start_req(a, rw, d, t0, 1'b0);
        wait_ack(name, t0);
        bus.req_cs = 1'b0;
    endtask

    initial begin
        int t0;
        rst          = 1'b1;
        bus.req_cs   = 1'b1;
        bus.req_addr = 32'h0000_0105;
        bus.req_rw   = 1'b1;
        bus.req_data = mk_block(32'hAAAA_0000);
        repeat (3) begin
            @(negedge clk);
            check_idle("reset_outputs");
        end

        // Release reset with the write already pending: accepted at the next edge.
        rst = 1'b0;
        t0  = cyc;
        start_req(32'h0000_0105, 1'b1, mk_block(32'hAAAA_0000), t0, 1'b0);
        wait_ack("write_105", t0);
        bus.req_cs = 1'b0;

        do_req("read_200", 32'h0000_0200, 1'b0, '0);
        do_req("read_203", 32'h0000_0203, 1'b0, '0);
`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
        do_req("read_cwf_0e", 32'h0000_000E, 1'b0, '0);
`endif

        // Back-to-back: req_cs held through ack, switched to a write in the RESP cycle.
        @(negedge clk);
        t0 = cyc;
        start_req(32'h0000_0300, 1'b0, '0, t0, 1'b0);
        wait_ack("b2b_read", t0);
        t0 = cyc + 1;
        start_req(32'h0000_0311, 1'b1, mk_block(32'h1234_5678), t0, 1'b0);
        wait_ack("b2b_write", t0);
        bus.req_cs = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (bus.resp_data !== exp_block) begin
            failures++;
            $display("FAIL hold_read_block got %h, expected %h", bus.resp_data, exp_block);
        end

        // Reset during the wait phase of a read: no ack, outputs cleared immediately.
        @(negedge clk);
        t0 = cyc;
        start_req(32'h0000_0400, 1'b0, '0, t0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        bus.req_cs = 1'b0;
        @(negedge clk);
        check_idle("abort_reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_after");
        checks++;
        if (ram_q.size() != 0 || ack_q.size() != 0) begin
            failures++;
            $display("FAIL abort_queues got ram_q=%0d ack_q=%0d pending, expected 0/0",
                     ram_q.size(), ack_q.size());
        end

        do_req("read_500", 32'h0000_0501, 1'b0, '0);
        do_req("write_510", 32'h0000_0510, 1'b1, mk_block(32'hCAFE_0000));

        repeat (5) @(negedge clk);
        checks++;
        if (ram_q.size() != 0 || ack_q.size() != 0) begin
            failures++;
            $display("FAIL final_queues got ram_q=%0d ack_q=%0d pending, expected 0/0",
                     ram_q.size(), ack_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
